fifo_row_loader: RTL and testbench

Upstream feeder for the router's multiple-input single-output FIFOs. On a start command it reads a programmed run of rows from an activation/weight SRAM (one row = DATA_LENGTH lanes of DATA_WIDTH bits) and writes each row into one FIFO as a single multi-lane write with a per-lane valid mask. It throttles on the FIFO's enough-slots flag and trims the final row to a programmed lane count.

---
 rtl/router_pkg.sv | 34 +++
 rtl/fifo_row_loader_if.sv | 36 +++
 rtl/fifo_row_loader.sv | 133 +++++++++++++
 tb/tb_fifo_row_loader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the router feeder blocks.
//
// Contents:
//   loader_state_e : sequencing states of the FIFO row loader
//   MAX_LANES      : widest lane mask lane_mask() can build
//   lane_mask()    : lane count -> thermometer mask of valid lanes
package router_pkg;

    localparam int unsigned MAX_LANES = 64;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        WRITE,
        DONE
    } loader_state_e;

    // Builds a thermometer mask for a row of `lanes` lanes. A count of 0 or
    // more than `lanes` means the whole row is valid, so a programmed count
    // of 0 behaves like a full row.
    function automatic logic [MAX_LANES-1:0] lane_mask(input int unsigned count,
                                                       input int unsigned lanes);
        logic [MAX_LANES-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < MAX_LANES; i++) begin
            if ((i < lanes) && ((count == 0) || (count > lanes) || (i < count))) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/fifo_row_loader_if.sv
// SRAM read port and FIFO write port of the row loader, bundled together.
//
// Signals:
//   sram_en / sram_addr   : read strobe and address toward the SRAM
//   sram_rdata            : read data, valid one cycle after sram_en
//   fifo_enough_slots     : FIFO can take a full multi-lane write
//   fifo_write_en         : FIFO write strobe
//   fifo_data / fifo_valid: lane data and per-lane valid mask
// Modports:
//   master : the loader side
//   slave  : the SRAM/FIFO side
interface fifo_row_loader_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int DATA_LENGTH = 8,
    parameter int ADDR_WIDTH  = 10
);

    logic                              sram_en;
    logic [ADDR_WIDTH-1:0]             sram_addr;
    logic [DATA_LENGTH*DATA_WIDTH-1:0] sram_rdata;
    logic                              fifo_enough_slots;
    logic                              fifo_write_en;
    logic [DATA_LENGTH*DATA_WIDTH-1:0] fifo_data;
    logic [DATA_LENGTH-1:0]            fifo_valid;

    modport master (
        output sram_en, sram_addr, fifo_write_en, fifo_data, fifo_valid,
        input  sram_rdata, fifo_enough_slots
    );

    modport slave (
        input  sram_en, sram_addr, fifo_write_en, fifo_data, fifo_valid,
        output sram_rdata, fifo_enough_slots
    );

endinterface

// File: rtl/fifo_row_loader.sv
// Reads a programmed run of rows from SRAM and writes each row into a
// multi-input FIFO as one multi-lane write. Throttles on the FIFO's
// enough-slots flag and trims the final row to a programmed lane count.
//
// Ports:
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_start        : one-cycle command pulse, honoured only when idle
//   i_clear        : synchronous abort back to idle
//   i_base_addr    : address of the first row
//   i_stride       : address increment between rows (wraps)
//   i_row_count    : number of rows in the run
//   i_last_lanes   : valid lanes in the final row (0 or too large = all)
//   bus            : SRAM read / FIFO write port (master side)
//   o_busy         : high whenever a run is in progress
//   o_done         : one-cycle pulse at the end of a run
module fifo_row_loader
    import router_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int DATA_LENGTH = 8,
    parameter int ADDR_WIDTH  = 10,
    parameter int COUNT_WIDTH = 8,
    parameter int LANE_WIDTH  = $clog2(DATA_LENGTH + 1)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic                   i_clear,
    input  logic [ADDR_WIDTH-1:0]  i_base_addr,
    input  logic [ADDR_WIDTH-1:0]  i_stride,
    input  logic [COUNT_WIDTH-1:0] i_row_count,
    input  logic [LANE_WIDTH-1:0]  i_last_lanes,
    fifo_row_loader_if.master      bus,
    output logic                   o_busy,
    output logic                   o_done
);

    loader_state_e state_q;
    loader_state_e state_d;

    logic [ADDR_WIDTH-1:0]             addr_q;
    logic [ADDR_WIDTH-1:0]             stride_q;
    logic [COUNT_WIDTH-1:0]            rows_q;
    logic [LANE_WIDTH-1:0]             last_q;
    logic [DATA_LENGTH*DATA_WIDTH-1:0] data_q;
    logic [DATA_LENGTH-1:0]            valid_q;
    logic [DATA_LENGTH-1:0]            last_mask;
    logic                              abort;

    assign abort     = i_rst | i_clear;
    assign last_mask = DATA_LENGTH'(lane_mask(32'(last_q), DATA_LENGTH));

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. rows_q already counts the row just read when WRITE
    // decides, so zero there means the run is finished. A clear overrides
    // every transition, including a start arriving in the same cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (i_start) state_d = (i_row_count == '0) ? DONE : ISSUE;
            ISSUE:   if (bus.fifo_enough_slots) state_d = WAIT;
            WAIT:    state_d = WRITE;
            WRITE:   state_d = (rows_q == '0) ? DONE : ISSUE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (i_clear) begin
            state_d = IDLE;
        end
    end

    // Run parameters, address accumulator, row counter and the FIFO-facing
    // data/mask registers. Data is captured in WAIT, the cycle the SRAM
    // answers; an abort in WAIT therefore simply drops the returned row.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_q   <= '0;
            stride_q <= '0;
            rows_q   <= '0;
            last_q   <= '0;
            data_q   <= '0;
            valid_q  <= '0;
        end else if (!i_clear) begin
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        addr_q   <= i_base_addr;
                        stride_q <= i_stride;
                        rows_q   <= i_row_count;
                        last_q   <= i_last_lanes;
                    end
                end
                WAIT: begin
                    data_q  <= bus.sram_rdata;
                    valid_q <= (rows_q == COUNT_WIDTH'(1)) ? last_mask : '1;
                    addr_q  <= addr_q + stride_q;
                    rows_q  <= rows_q - COUNT_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    // Strobes. They are gated by an abort in the same cycle so a clear in
    // ISSUE/WRITE/DONE never lets a read, write or done pulse escape.
    always_comb begin
        bus.sram_en       = 1'b0;
        bus.fifo_write_en = 1'b0;
        o_done            = 1'b0;
        if (!abort) begin
            case (state_q)
                ISSUE:   bus.sram_en       = bus.fifo_enough_slots;
                WRITE:   bus.fifo_write_en = 1'b1;
                DONE:    o_done            = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.sram_addr  = addr_q;
    assign bus.fifo_data  = data_q;
    assign bus.fifo_valid = valid_q;
    assign o_busy         = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_row_loader.sv
// Self-checking bench for fifo_row_loader: reset values, a table of
// directed runs, hand-written abort sequences and randomized runs, all
// checked against a reference model of addresses, masks and run timing.
module tb_fifo_row_loader;

    localparam int DW = 8;
    localparam int DL = 8;
    localparam int AW = 10;
    localparam int CW = 8;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          clear;
    logic [AW-1:0] base;
    logic [AW-1:0] stride;
    logic [CW-1:0] rows;
    logic [LW-1:0] last_lanes;
    logic          busy;
    logic          done;

    int n_vectors     = 0;
    int n_miscompares = 0;

    logic [DL*DW-1:0] mem [0:1023];

    fifo_row_loader_if #(.DATA_WIDTH(DW), .DATA_LENGTH(DL), .ADDR_WIDTH(AW)) bus ();

    fifo_row_loader #(
        .DATA_WIDTH(DW), .DATA_LENGTH(DL), .ADDR_WIDTH(AW),
        .COUNT_WIDTH(CW), .LANE_WIDTH(LW)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_clear(clear),
        .i_base_addr(base), .i_stride(stride), .i_row_count(rows),
        .i_last_lanes(last_lanes), .bus(bus), .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    // SRAM model: data is valid only in the cycle after a read strobe;
    // garbage otherwise so mistimed captures are visible.
    always @(posedge clk) begin
        if (bus.sram_en) bus.sram_rdata <= mem[bus.sram_addr];
        else             bus.sram_rdata <= {$urandom, $urandom};
    end

    typedef struct {
        string      tag;
        logic [9:0] base;
        logic [9:0] stride;
        int         rows;
        int         last_lanes;
        int         stall_row;
        int         stall_len;
        int         start_pulse;
        int         exp_done;
        logic [9:0] exp_last_addr;
        logic [7:0] exp_last_mask;
    } vec_t;

    vec_t vecs [8];

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [9:0] exp_addr(input logic [9:0] b, input logic [9:0] s, input int k);
        return 10'((int'(b) + k * int'(s)) % 1024);
    endfunction

    function automatic logic [7:0] exp_mask(input int ll);
        if (ll == 0 || ll > 8) return 8'hFF;
        return 8'((1 << ll) - 1);
    endfunction

    function automatic logic [63:0] expand_mask(input logic [7:0] m);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = {8{m[i]}};
        return r;
    endfunction

    // One complete run. Stall cycles are placed at the start of the chosen
    // ISSUE windows; every other cycle drives enough_slots randomly since
    // only ISSUE may look at it. Parameter inputs are scrambled after the
    // start cycle, and an optional extra start pulse lands mid-run.
    task automatic applyStimulus(input string tag, input logic [9:0] b, input logic [9:0] s,
                                 input int n, input int ll, input int stall_row,
                                 input int stall_len, input int start_pulse,
                                 input bit rand_stalls, input int exp_done_in,
                                 input logic [9:0] exp_last_addr, input logic [7:0] exp_last_mask);
        int         stall [$];
        bit         sched [0:511];
        int         issue_c, en_c, total_stall, exp_done, st;
        int         rd_idx, wr_idx, last_en, done_c;
        logic [9:0] last_addr_seen;
        logic [7:0] m;
        bit         en_blocked;
        total_stall = 0;
        rd_idx = 0; wr_idx = 0; last_en = -100; done_c = -1;
        last_addr_seen = '0; en_blocked = 1'b0;
        for (int k = 0; k < n; k++) begin
            st = rand_stalls ? int'($urandom_range(0, 3)) : ((k == stall_row) ? stall_len : 0);
            stall.push_back(st);
            total_stall += st;
        end
        for (int c = 0; c < 512; c++) sched[c] = 1'($urandom_range(0, 1));
        issue_c = 1;
        for (int k = 0; k < n; k++) begin
            en_c = issue_c + stall[k];
            for (int c = issue_c; c < en_c; c++) sched[c] = 1'b0;
            sched[en_c] = 1'b1;
            issue_c = en_c + 3;
        end
        exp_done = (exp_done_in >= 0) ? exp_done_in : 3 * n + 1 + total_stall;

        @(posedge clk); #1;
        start = 1'b1; clear = 1'b0;
        base = b; stride = s; rows = n[7:0]; last_lanes = ll[3:0];
        bus.fifo_enough_slots = sched[0];
        @(negedge clk);
        checkOutput({tag, " busy before start"}, 64'(busy), 64'(0));

        for (int c = 1; c <= exp_done + 4 && done_c < 0; c++) begin
            @(posedge clk); #1;
            start = (c == start_pulse);
            base = 10'($urandom); stride = 10'($urandom);
            rows = 8'($urandom); last_lanes = 4'($urandom);
            bus.fifo_enough_slots = sched[c];
            @(negedge clk);
            if (c == 1) checkOutput({tag, " busy in run"}, 64'(busy), 64'(1));
            if (bus.sram_en) begin
                if (!bus.fifo_enough_slots) en_blocked = 1'b1;
                if (rd_idx < n)
                    checkOutput({tag, " read addr"}, 64'(bus.sram_addr), 64'(exp_addr(b, s, rd_idx)));
                last_addr_seen = bus.sram_addr;
                last_en = c;
                rd_idx++;
            end
            if (bus.fifo_write_en) begin
                if (wr_idx < n) begin
                    m = (wr_idx == n - 1) ? exp_last_mask : 8'hFF;
                    checkOutput({tag, " write valid"}, 64'(bus.fifo_valid), 64'(m));
                    checkOutput({tag, " write data"}, bus.fifo_data & expand_mask(m),
                                mem[exp_addr(b, s, wr_idx)] & expand_mask(m));
                    checkOutput({tag, " read-to-write latency"}, 64'(c - last_en), 64'(2));
                end
                wr_idx++;
            end
            if (done) done_c = c;
        end

        checkOutput({tag, " done cycle"}, 64'(done_c), 64'(exp_done));
        checkOutput({tag, " read count"}, 64'(rd_idx), 64'(n));
        checkOutput({tag, " write count"}, 64'(wr_idx), 64'(n));
        checkOutput({tag, " read while FIFO full"}, 64'(en_blocked), 64'(0));
        if (n > 0) checkOutput({tag, " last read addr"}, 64'(last_addr_seen), 64'(exp_last_addr));

        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput({tag, " idle after done"}, 64'({busy, done}), 64'(0));
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int         writes;
        bit         activity;
        logic [9:0] b, s;
        int         n, ll;

        for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom};

        vecs[0] = '{"basic",        10'h010, 10'h001, 3, 8, -1, 0, 0, 10, 10'h012, 8'hFF};
        vecs[1] = '{"partial last", 10'h100, 10'h004, 2, 3, -1, 0, 0,  7, 10'h104, 8'h07};
        vecs[2] = '{"backpressure", 10'h020, 10'h001, 3, 8,  1, 5, 0, 15, 10'h022, 8'hFF};
        vecs[3] = '{"wrap stride",  10'h3FE, 10'h002, 3, 8, -1, 0, 0, 10, 10'h002, 8'hFF};
        vecs[4] = '{"zero rows",    10'h123, 10'h001, 0, 8, -1, 0, 0,  1, 10'h000, 8'hFF};
        vecs[5] = '{"lanes zero",   10'h055, 10'h007, 1, 0, -1, 0, 0,  4, 10'h055, 8'hFF};
        vecs[6] = '{"lanes nine",   10'h0F0, 10'h010, 2, 9, -1, 0, 0,  7, 10'h100, 8'hFF};
        vecs[7] = '{"start busy",   10'h200, 10'h003, 4, 5, -1, 0, 5, 13, 10'h209, 8'h1F};

        rst = 1'b1; start = 1'b0; clear = 1'b0;
        base = '0; stride = '0; rows = '0; last_lanes = '0;
        bus.fifo_enough_slots = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset sram_en",    64'(bus.sram_en),       64'(0));
        checkOutput("reset sram_addr",  64'(bus.sram_addr),     64'(0));
        checkOutput("reset write_en",   64'(bus.fifo_write_en), 64'(0));
        checkOutput("reset fifo_data",  bus.fifo_data,          64'(0));
        checkOutput("reset fifo_valid", 64'(bus.fifo_valid),    64'(0));
        checkOutput("reset busy",       64'(busy),              64'(0));
        checkOutput("reset done",       64'(done),              64'(0));

        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].tag, vecs[v].base, vecs[v].stride, vecs[v].rows,
                          vecs[v].last_lanes, vecs[v].stall_row, vecs[v].stall_len,
                          vecs[v].start_pulse, 1'b0, vecs[v].exp_done,
                          vecs[v].exp_last_addr, vecs[v].exp_last_mask);
        end

        // Clear during the WRITE of the second of four rows.
        @(posedge clk); #1;
        start = 1'b1; base = 10'h040; stride = 10'h001; rows = 8'd4; last_lanes = 4'd8;
        bus.fifo_enough_slots = 1'b1; clear = 1'b0;
        writes = 0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            start = 1'b0; clear = (c == 6);
            @(negedge clk);
            if (c < 6 && bus.fifo_write_en) writes++;
            if (c == 6) begin
                checkOutput("abort write suppressed", 64'(bus.fifo_write_en), 64'(0));
                checkOutput("abort done low", 64'(done), 64'(0));
            end
        end
        checkOutput("abort writes before clear", 64'(writes), 64'(1));
        @(posedge clk); #1 clear = 1'b0;
        @(negedge clk);
        checkOutput("abort busy after clear", 64'(busy), 64'(0));
        activity = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (done || bus.sram_en || bus.fifo_write_en) activity = 1'b1;
        end
        checkOutput("abort quiet after clear", 64'(activity), 64'(0));

        // Clear in the first ISSUE cycle with slots available.
        @(posedge clk); #1;
        start = 1'b1; base = 10'h080; rows = 8'd2;
        @(posedge clk); #1;
        start = 1'b0; clear = 1'b1;
        @(negedge clk);
        checkOutput("clear in issue drops read", 64'(bus.sram_en), 64'(0));
        @(posedge clk); #1 clear = 1'b0;
        @(negedge clk);
        checkOutput("clear in issue busy", 64'(busy), 64'(0));

        // Reset in the middle of a run zeroes the registered outputs too.
        @(posedge clk); #1;
        start = 1'b1; base = 10'h0C0; stride = 10'h001; rows = 8'd3; last_lanes = 4'd2;
        repeat (3) begin
            @(posedge clk); #1 start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        checkOutput("reset in write suppresses", 64'(bus.fifo_write_en), 64'(0));
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset mid-run state", 64'({busy, bus.fifo_valid, bus.sram_addr}), 64'(0));

        // Recovery plus randomized runs.
        for (int r = 0; r < 20; r++) begin
            b  = 10'($urandom);
            s  = 10'($urandom);
            n  = $urandom_range(0, 6);
            ll = $urandom_range(0, 15);
            applyStimulus("random", b, s, n, ll, -1, 0, $urandom_range(0, 8), 1'b1, -1,
                          exp_addr(b, s, n - 1), exp_mask(ll));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
